// File: rtl/mfcc_ctrl_pkg.sv
// Shared control definitions for the MFCC pipeline stage arbiters:
// FSM state encoding and default frame-counter width.
package mfcc_ctrl_pkg;

   localparam int FRAME_W_DEF = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_RUN   = ST_RUN,
      S_DRAIN = ST_DRAIN,
      S_DONE  = ST_DONE
   } arb_state_e;

endpackage

// File: rtl/pingpong_bank_flags.sv
// Full flags for the two ping-pong banks plus the write/read bank pointers.
// A set marks the write bank full and advances wr_ptr; a clear empties the read bank and advances rd_ptr.
module pingpong_bank_flags (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       set_full,
   input  logic       clr_full,
   output logic [1:0] bank_full,
   output logic       wr_ptr,
   output logic       rd_ptr
);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         // Set and clear never target the same bank: the producer only owns an empty bank.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               bank_full[gi] <= 1'b0;
            end else if (clr) begin
               bank_full[gi] <= 1'b0;
            end else if (set_full && (wr_ptr == 1'(gi))) begin
               bank_full[gi] <= 1'b1;
            end else if (clr_full && (rd_ptr == 1'(gi))) begin
               bank_full[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else if (clr) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (set_full) wr_ptr <= ~wr_ptr;
         if (clr_full) rd_ptr <= ~rd_ptr;
      end
   end

endmodule

// File: rtl/pingpong_buf_arbiter.sv
// Run-level arbiter for a two-bank buffer between a producer and a consumer stage:
// registered bank grants, frame counting, drain and protocol error tracking.
module pingpong_buf_arbiter
   import mfcc_ctrl_pkg::*;
#(
   parameter int FRAME_W = FRAME_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [FRAME_W-1:0] frame_total,
   input  logic               prod_req,
   input  logic               prod_done,
   input  logic               cons_req,
   input  logic               cons_done,
   output logic               prod_grant,
   output logic               prod_bank_sel,
   output logic               cons_grant,
   output logic               cons_bank_sel,
   output logic [1:0]         bank_full,
   output logic [FRAME_W-1:0] frames_consumed,
   output logic               busy,
   output logic               run_done,
   output logic               protocol_err
);

   arb_state_e         state_reg;
   logic [FRAME_W-1:0] total_reg;
   logic [FRAME_W-1:0] produced_reg;
   logic [FRAME_W-1:0] consumed_reg;
   logic               prod_grant_reg;
   logic               cons_grant_reg;
   logic               busy_reg;
   logic               run_done_reg;
   logic               protocol_err_reg;

   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         full_flags;

   logic               prod_acc;
   logic               cons_acc;
   logic               bad_done;
   logic               start_acc;
   logic               flags_clr;
   logic [FRAME_W-1:0] produced_inc;
   logic [FRAME_W-1:0] consumed_inc;

   always_comb begin
      prod_acc     = prod_done & prod_grant_reg;
      cons_acc     = cons_done & cons_grant_reg;
      bad_done     = (prod_done & ~prod_grant_reg) | (cons_done & ~cons_grant_reg);
      start_acc    = start & ~abort & ((state_reg == S_IDLE) | (state_reg == S_DONE));
      flags_clr    = abort | start_acc;
      produced_inc = produced_reg + FRAME_W'(1);
      consumed_inc = consumed_reg + FRAME_W'(1);
   end

   pingpong_bank_flags u_flags (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (flags_clr),
      .set_full  (prod_acc & ~abort),
      .clr_full  (cons_acc & ~abort),
      .bank_full (full_flags),
      .wr_ptr    (wr_ptr),
      .rd_ptr    (rd_ptr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= S_IDLE;
         total_reg        <= '0;
         produced_reg     <= '0;
         consumed_reg     <= '0;
         prod_grant_reg   <= 1'b0;
         cons_grant_reg   <= 1'b0;
         busy_reg         <= 1'b0;
         run_done_reg     <= 1'b0;
         protocol_err_reg <= 1'b0;
      end else if (abort) begin
         state_reg        <= S_IDLE;
         total_reg        <= '0;
         produced_reg     <= '0;
         consumed_reg     <= '0;
         prod_grant_reg   <= 1'b0;
         cons_grant_reg   <= 1'b0;
         busy_reg         <= 1'b0;
         run_done_reg     <= 1'b0;
         protocol_err_reg <= 1'b0;
      end else begin
         if (bad_done) protocol_err_reg <= 1'b1;

         if ((state_reg == S_IDLE) || (state_reg == S_DONE)) begin
            run_done_reg <= 1'b0;
            if (state_reg == S_DONE) state_reg <= S_IDLE;
            // A fresh run clears any error left by the previous one.
            if (start_acc) begin
               total_reg        <= frame_total;
               produced_reg     <= '0;
               consumed_reg     <= '0;
               protocol_err_reg <= 1'b0;
               if (frame_total == '0) begin
                  state_reg    <= S_DONE;
                  run_done_reg <= 1'b1;
               end else begin
                  state_reg <= S_RUN;
                  busy_reg  <= 1'b1;
               end
            end
         end

         if (state_reg == S_RUN) begin
            if (prod_acc) begin
               prod_grant_reg <= 1'b0;
               produced_reg   <= produced_inc;
               if (produced_inc == total_reg) state_reg <= S_DRAIN;
            end else if (prod_req && !prod_grant_reg && !full_flags[wr_ptr]) begin
               prod_grant_reg <= 1'b1;
            end
         end

         if ((state_reg == S_RUN) || (state_reg == S_DRAIN)) begin
            if (cons_acc) begin
               cons_grant_reg <= 1'b0;
               consumed_reg   <= consumed_inc;
               if ((state_reg == S_DRAIN) && (consumed_inc == total_reg)) begin
                  state_reg    <= S_DONE;
                  busy_reg     <= 1'b0;
                  run_done_reg <= 1'b1;
               end
            end else if (cons_req && !cons_grant_reg && full_flags[rd_ptr]) begin
               cons_grant_reg <= 1'b1;
            end
         end
      end
   end

   assign prod_grant      = prod_grant_reg;
   assign prod_bank_sel   = wr_ptr;
   assign cons_grant      = cons_grant_reg;
   assign cons_bank_sel   = rd_ptr;
   assign bank_full       = full_flags;
   assign frames_consumed = consumed_reg;
   assign busy            = busy_reg;
   assign run_done        = run_done_reg;
   assign protocol_err    = protocol_err_reg;

   // Structural invariants: no overwrite, no under-read, counters ordered and bounded.
   a_no_overwrite : assert property (@(posedge clk) disable iff (!rst_n)
      prod_grant_reg |-> !full_flags[wr_ptr]);
   a_no_underread : assert property (@(posedge clk) disable iff (!rst_n)
      cons_grant_reg |-> full_flags[rd_ptr]);
   a_split_banks : assert property (@(posedge clk) disable iff (!rst_n)
      (prod_acc && cons_acc) |-> (wr_ptr != rd_ptr));
   a_count_order : assert property (@(posedge clk) disable iff (!rst_n)
      (consumed_reg <= produced_reg) && (produced_reg <= total_reg));

endmodule

// File: tb/tb_pingpong_buf_arbiter.sv
// Directed bench for pingpong_buf_arbiter: one task per scenario, inline checks.
`timescale 1ns/1ps
module tb_pingpong_buf_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, abort;
   logic [7:0] frame_total;
   logic       prod_req, prod_done, cons_req, cons_done;
   logic       prod_grant, prod_bank_sel, cons_grant, cons_bank_sel;
   logic [1:0] bank_full;
   logic [7:0] frames_consumed;
   logic       busy, run_done, protocol_err;

   int n_checks = 0;
   int n_bad    = 0;

   // agent state
   logic prod_en, cons_en;
   int   pcnt, ccnt, rd_cnt;
   logic prod_banks[$];
   logic cons_banks[$];
   logic [7:0] fc_at_done;
   logic busy_at_done, busy_prev_at_done;

   always #5 clk = ~clk;

   pingpong_buf_arbiter #(.FRAME_W(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .abort           (abort),
      .frame_total     (frame_total),
      .prod_req        (prod_req),
      .prod_done       (prod_done),
      .cons_req        (cons_req),
      .cons_done       (cons_done),
      .prod_grant      (prod_grant),
      .prod_bank_sel   (prod_bank_sel),
      .cons_grant      (cons_grant),
      .cons_bank_sel   (cons_bank_sel),
      .bank_full       (bank_full),
      .frames_consumed (frames_consumed),
      .busy            (busy),
      .run_done        (run_done),
      .protocol_err    (protocol_err)
   );

   function automatic logic [16:0] outs();
      return {prod_grant, prod_bank_sel, cons_grant, cons_bank_sel, bank_full,
              frames_consumed, busy, run_done, protocol_err};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic agent_clear();
      pcnt = 0; ccnt = 0; rd_cnt = 0;
      prod_banks.delete();
      cons_banks.delete();
      fc_at_done = '0; busy_at_done = 1'bx; busy_prev_at_done = 1'bx;
   endtask

   // One cycle of producer/consumer behaviour: done on the third cycle a grant is seen.
   task automatic agent_cycle();
      logic busy_before;
      prod_done = 1'b0; cons_done = 1'b0;
      prod_req = prod_en; cons_req = cons_en;
      if (prod_grant) begin
         pcnt++;
         if (pcnt == 1) prod_banks.push_back(prod_bank_sel);
         if (pcnt == 3) prod_done = 1'b1;
      end else pcnt = 0;
      if (cons_grant) begin
         ccnt++;
         if (ccnt == 1) cons_banks.push_back(cons_bank_sel);
         if (ccnt == 3) cons_done = 1'b1;
      end else ccnt = 0;
      busy_before = busy;
      tick();
      prod_done = 1'b0; cons_done = 1'b0;
      if (run_done) begin
         rd_cnt++;
         fc_at_done = frames_consumed;
         busy_at_done = busy;
         busy_prev_at_done = busy_before;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 0; abort = 0; frame_total = '0;
      prod_req = 0; prod_done = 0; cons_req = 0; cons_done = 0;
      prod_en = 0; cons_en = 0;
      repeat (3) tick();
      n_checks++;
      if (outs() !== 17'd0) begin
         n_bad++; $display("FAIL reset_outs got=%h want=0", outs());
      end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (outs() !== 17'd0) begin
         n_bad++; $display("FAIL after_reset_outs got=%h want=0", outs());
      end
      $display("reset: outs=%h", outs());
   endtask

   task automatic test_basic_run();
      logic exp_b [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      agent_clear();
      frame_total = 8'd4; start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got=%b want=1", busy); end
      prod_en = 1; cons_en = 1;
      for (int i = 0; i < 300 && rd_cnt == 0; i++) agent_cycle();
      n_checks++;
      if (rd_cnt == 0) begin n_bad++; $display("FAIL basic_timeout got=no run_done want=run_done"); end
      repeat (5) agent_cycle();
      prod_en = 0; cons_en = 0; prod_req = 0; cons_req = 0;
      n_checks++;
      if (rd_cnt !== 1) begin n_bad++; $display("FAIL basic_run_done_pulses got=%0d want=1", rd_cnt); end
      n_checks++;
      if (fc_at_done !== 8'd4) begin n_bad++; $display("FAIL basic_frames got=%0d want=4", fc_at_done); end
      n_checks++;
      if (busy_at_done !== 1'b0 || busy_prev_at_done !== 1'b1) begin
         n_bad++; $display("FAIL basic_busy_fall got=%b->%b want=1->0", busy_prev_at_done, busy_at_done);
      end
      n_checks++;
      if (prod_banks.size() != 4 || cons_banks.size() != 4) begin
         n_bad++; $display("FAIL basic_grant_count got=%0d/%0d want=4/4", prod_banks.size(), cons_banks.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (prod_banks[i] !== exp_b[i] || cons_banks[i] !== exp_b[i]) begin
            n_bad++; $display("FAIL basic_bank_seq[%0d] got=%b/%b want=%b", i, prod_banks[i], cons_banks[i], exp_b[i]);
         end
      end
      $display("basic run: frames=%0d run_done_pulses=%0d", fc_at_done, rd_cnt);
   endtask

   task automatic test_backpressure();
      agent_clear();
      frame_total = 8'd6; start = 1'b1;
      tick();
      start = 1'b0;
      prod_en = 1; cons_en = 0;
      repeat (20) agent_cycle();
      n_checks++;
      if (bank_full !== 2'b11) begin n_bad++; $display("FAIL bp_full got=%b want=11", bank_full); end
      n_checks++;
      if (prod_grant !== 1'b0) begin n_bad++; $display("FAIL bp_prod_stall got=%b want=0", prod_grant); end
      n_checks++;
      if (prod_banks.size() != 2) begin n_bad++; $display("FAIL bp_prod_grants got=%0d want=2", prod_banks.size()); end
      cons_en = 1;
      for (int i = 0; i < 400 && rd_cnt == 0; i++) agent_cycle();
      prod_en = 0; cons_en = 0; prod_req = 0; cons_req = 0;
      tick();
      n_checks++;
      if (rd_cnt !== 1 || fc_at_done !== 8'd6) begin
         n_bad++; $display("FAIL bp_complete got=pulses %0d frames %0d want=pulses 1 frames 6", rd_cnt, fc_at_done);
      end
      $display("backpressure: frames=%0d", fc_at_done);
   endtask

   task automatic test_simultaneous();
      frame_total = 8'd4; start = 1'b1;
      tick();
      start = 1'b0; prod_req = 1'b1;
      tick();
      prod_done = 1'b1;
      tick();
      prod_done = 1'b0; cons_req = 1'b1;
      tick();
      n_checks++;
      if ({prod_grant, prod_bank_sel, cons_grant, cons_bank_sel, bank_full} !== 6'b11_10_01) begin
         n_bad++; $display("FAIL simul_pre got=%b%b%b%b %b want=1110 01",
                           prod_grant, prod_bank_sel, cons_grant, cons_bank_sel, bank_full);
      end
      prod_req = 0; cons_req = 0; prod_done = 1'b1; cons_done = 1'b1;
      tick();
      prod_done = 0; cons_done = 0;
      n_checks++;
      if (bank_full !== 2'b10) begin n_bad++; $display("FAIL simul_full got=%b want=10", bank_full); end
      n_checks++;
      if (prod_bank_sel !== 1'b0 || cons_bank_sel !== 1'b1) begin
         n_bad++; $display("FAIL simul_ptrs got=wr%b rd%b want=wr0 rd1", prod_bank_sel, cons_bank_sel);
      end
      n_checks++;
      if (prod_grant !== 1'b0 || cons_grant !== 1'b0 || frames_consumed !== 8'd1) begin
         n_bad++; $display("FAIL simul_after got=pg%b cg%b fc%0d want=pg0 cg0 fc1", prod_grant, cons_grant, frames_consumed);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      $display("simultaneous: bank_full=%b wr=%b rd=%b", 2'b10, 1'b0, 1'b1);
   endtask

   task automatic test_protocol_err();
      prod_done = 1'b1;
      tick();
      prod_done = 1'b0;
      n_checks++;
      if ({protocol_err, bank_full, frames_consumed, prod_bank_sel} !== {1'b1, 2'b00, 8'd0, 1'b0}) begin
         n_bad++; $display("FAIL perr_idle got=err%b full%b fc%0d wr%b want=err1 full00 fc0 wr0",
                           protocol_err, bank_full, frames_consumed, prod_bank_sel);
      end
      cons_done = 1'b1;
      tick();
      cons_done = 1'b0;
      tick();
      n_checks++;
      if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL perr_sticky got=%b want=1", protocol_err); end
      frame_total = 8'd2; start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (protocol_err !== 1'b0 || busy !== 1'b1) begin
         n_bad++; $display("FAIL perr_start_clear got=err%b busy%b want=err0 busy1", protocol_err, busy);
      end
      prod_done = 1'b1;
      tick();
      prod_done = 1'b0;
      n_checks++;
      if ({protocol_err, bank_full, frames_consumed, prod_bank_sel} !== {1'b1, 2'b00, 8'd0, 1'b0}) begin
         n_bad++; $display("FAIL perr_run got=err%b full%b fc%0d wr%b want=err1 full00 fc0 wr0",
                           protocol_err, bank_full, frames_consumed, prod_bank_sel);
      end
      $display("protocol_err: err=%b", protocol_err);
   endtask

   task automatic test_start_while_busy();
      agent_clear();
      frame_total = 8'd7; start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (protocol_err !== 1'b1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL busy_start_ignored got=err%b busy%b want=err1 busy1", protocol_err, busy);
      end
      prod_en = 1; cons_en = 1;
      for (int i = 0; i < 400 && rd_cnt == 0; i++) agent_cycle();
      prod_en = 0; cons_en = 0; prod_req = 0; cons_req = 0;
      tick();
      n_checks++;
      if (rd_cnt !== 1 || fc_at_done !== 8'd2) begin
         n_bad++; $display("FAIL busy_no_relatch got=pulses %0d frames %0d want=pulses 1 frames 2", rd_cnt, fc_at_done);
      end
      $display("start while busy: frames=%0d", fc_at_done);
   endtask

   task automatic test_zero_frames();
      prod_req = 1; cons_req = 1;
      frame_total = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({run_done, busy, prod_grant, cons_grant} !== 4'b1000) begin
         n_bad++; $display("FAIL zero_done got=rd%b busy%b pg%b cg%b want=rd1 busy0 pg0 cg0",
                           run_done, busy, prod_grant, cons_grant);
      end
      tick();
      n_checks++;
      if ({run_done, prod_grant, cons_grant} !== 3'b000) begin
         n_bad++; $display("FAIL zero_after got=rd%b pg%b cg%b want=000", run_done, prod_grant, cons_grant);
      end
      prod_req = 0; cons_req = 0;
      $display("zero frames: run_done pulse seen");
   endtask

   task automatic test_abort_reset();
      frame_total = 8'd1; start = 1'b1;
      tick();
      start = 1'b0; prod_req = 1'b1;
      tick();
      prod_req = 1'b0; prod_done = 1'b1;
      tick();
      prod_done = 1'b0;
      n_checks++;
      if ({bank_full, busy, prod_bank_sel} !== 4'b01_1_1) begin
         n_bad++; $display("FAIL drain_pre got=full%b busy%b wr%b want=full01 busy1 wr1", bank_full, busy, prod_bank_sel);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++;
      if (outs() !== 17'd0) begin n_bad++; $display("FAIL abort_outs got=%h want=0", outs()); end
      frame_total = 8'd3; start = 1'b1;
      tick();
      start = 1'b0; prod_req = 1'b1;
      tick();
      prod_req = 1'b0; prod_done = 1'b1;
      tick();
      prod_done = 1'b0; cons_req = 1'b1;
      tick();
      n_checks++;
      if ({busy, cons_grant, bank_full} !== 4'b1_1_01) begin
         n_bad++; $display("FAIL midrun_pre got=busy%b cg%b full%b want=busy1 cg1 full01", busy, cons_grant, bank_full);
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (outs() !== 17'd0) begin n_bad++; $display("FAIL async_reset_outs got=%h want=0", outs()); end
      cons_req = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (outs() !== 17'd0) begin n_bad++; $display("FAIL post_reset_outs got=%h want=0", outs()); end
      frame_total = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (run_done !== 1'b1) begin n_bad++; $display("FAIL post_reset_idle got=%b want=1", run_done); end
      $display("abort/reset: outs cleared");
   endtask

   initial begin
      test_reset();
      test_basic_run();
      test_backpressure();
      test_simultaneous();
      test_protocol_err();
      test_start_while_busy();
      test_zero_frames();
      test_abort_reset();
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
